sorted_insert: RTL and testbench

- Writer-side companion to the binary-search engine: it builds and maintains the sorted table that the search block reads.
- Keys arrive one at a time on an en/X strobe. Each key is placed in ascending order by a sequential insertion-sort shift, one slot per cycle.
- The table is presented as a packed bus in the same layout the search block consumes: element 0 (smallest) in the MSB byte.
- Unused slots hold the all-ones value, so the bus is always a valid sorted array.

---
 rtl/sorted_insert.sv | 103 ++++++++++
 tb/tb_sorted_insert.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sorted_insert.sv
// rtl/sorted_insert.sv - insertion-sort writer for the packed ascending key table
// One shift decision per clock; unused slots hold all ones so the bus stays sorted.
module sorted_insert #(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [W-1:0]           X,
  input  logic                   clr,
  output logic [N*W-1:0]         data,
  output logic [$clog2(N+1)-1:0] count,
  output logic                   rdy,
  output logic                   full,
  output logic                   err
);

  localparam int CW = $clog2(N+1);
  localparam int JW = $clog2(N) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  slot_q [N];
  logic [W-1:0]  slot_d [N];
  logic [CW-1:0] count_q, count_d;
  logic [JW-1:0] j_q, j_d;
  logic [W-1:0]  key_q, key_d;
  logic          err_q, err_d;
  logic [W-1:0]  cur;
  logic [JW-1:0] jp1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    j_d     = j_q;
    key_d   = key_q;
    err_d   = 1'b0;
    for (int i = 0; i < N; i++) slot_d[i] = slot_q[i];
    cur = '1;
    for (int i = 0; i < N; i++) if (JW'(i) == j_q) cur = slot_q[i];
    jp1 = j_q + JW'(1);

    case (state_q)
      IDLE: begin
        if (clr) begin
          for (int i = 0; i < N; i++) slot_d[i] = '1;
          count_d = '0;
        end else if (en) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            key_d   = X;
            j_d     = JW'(count_q) - JW'(1);
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        // j_q MSB set means j = -1: every existing entry was moved up
        if (!j_q[JW-1] && (cur > key_q)) begin
          for (int i = 0; i < N; i++) if (JW'(i) == jp1) slot_d[i] = cur;
          j_d = j_q - JW'(1);
        end else begin
          for (int i = 0; i < N; i++) if (JW'(i) == jp1) slot_d[i] = key_q;
          count_d = count_q + CW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      j_q     <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N; i++) slot_q[i] <= '1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      j_q     <= j_d;
      key_q   <= key_d;
      err_q   <= err_d;
      for (int i = 0; i < N; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < N; i++) data[N*W-1-i*W -: W] = slot_q[i];
  end

  assign count = count_q;
  assign rdy   = (state_q == IDLE);
  assign full  = (count_q == CW'(N));
  assign err   = err_q;

endmodule

// File: tb/tb_sorted_insert.sv
// tb/tb_sorted_insert.sv - directed self-checking bench for sorted_insert
module tb_sorted_insert;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [7:0]  X   = 8'd0;
  logic        clr = 1'b0;
  logic [63:0] data;
  logic [3:0]  count;
  logic        rdy, full, err;

  int n_cmp = 0;
  int n_bad = 0;

  sorted_insert #(.W(8), .N(8)) dut (
    .clk(clk), .rst(rst), .en(en), .X(X), .clr(clr),
    .data(data), .count(count), .rdy(rdy), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Returns the number of cycles rdy stayed low, or -1 if it never came back.
  task automatic do_insert(input logic [7:0] key, output int busy);
    @(negedge clk);
    en = 1'b1;
    X  = key;
    @(posedge clk);
    #1 en = 1'b0;
    busy = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdy) return;
      busy++;
    end
    busy = -1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL reset_data got %h want %h", data, 64'hFFFF_FFFF_FFFF_FFFF); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b want 1", rdy); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_basic();
    int b;
    logic [63:0] exp;
    do_insert(8'd50, b);
    n_cmp++; if (b !== 1) begin n_bad++; $display("FAIL basic_busy50 got %0d want 1", b); end
    do_insert(8'd30, b);
    n_cmp++; if (b !== 2) begin n_bad++; $display("FAIL basic_busy30 got %0d want 2", b); end
    do_insert(8'd90, b);
    n_cmp++; if (b !== 1) begin n_bad++; $display("FAIL basic_busy90 got %0d want 1", b); end
    exp = {8'd30, 8'd50, 8'd90, 40'hFF_FFFF_FFFF};
    n_cmp++; if (data !== exp) begin n_bad++; $display("FAIL basic_data got %h want %h", data, exp); end
    n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL basic_count got %0d want 3", count); end
  endtask

  task automatic test_fill();
    int b;
    logic [63:0] exp;
    logic [7:0] keys [8];
    keys = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20};
    do_clear();
    for (int k = 0; k < 8; k++) do_insert(keys[k], b);
    exp = {8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    n_cmp++; if (b !== 8) begin n_bad++; $display("FAIL fill_last_busy got %0d want 8", b); end
    n_cmp++; if (data !== exp) begin n_bad++; $display("FAIL fill_data got %h want %h", data, exp); end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full got %b want 1", full); end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fill_count got %0d want 8", count); end
  endtask

  task automatic test_full_err();
    logic [63:0] exp;
    exp = {8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    @(negedge clk);
    en = 1'b1;
    X  = 8'd10;
    @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL full_err_pulse got %b want 1", err); end
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL full_err_rdy got %b want 1", rdy); end
    n_cmp++; if (data !== exp) begin n_bad++; $display("FAIL full_err_data got %h want %h", data, exp); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_err_drop got %b want 0", err); end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_err_count got %0d want 8", count); end
  endtask

  task automatic test_dup_and_clr();
    int b;
    logic [63:0] exp;
    do_clear();
    do_insert(8'd40, b);
    do_insert(8'd40, b);
    do_insert(8'd40, b);
    exp = {8'd40, 8'd40, 8'd40, 40'hFF_FFFF_FFFF};
    n_cmp++; if (b !== 1) begin n_bad++; $display("FAIL dup_busy got %0d want 1", b); end
    n_cmp++; if (data !== exp) begin n_bad++; $display("FAIL dup_data got %h want %h", data, exp); end
    @(negedge clk);
    clr = 1'b1;
    en  = 1'b1;
    X   = 8'd7;
    @(posedge clk);
    #1 begin clr = 1'b0; en = 1'b0; end
    @(negedge clk);
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL clr_en_count got %0d want 0", count); end
    n_cmp++; if (data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL clr_en_data got %h want all ones", data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clr_en_err got %b want 0", err); end
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL clr_en_rdy got %b want 1", rdy); end
  endtask

  task automatic test_reset_mid_and_ignore();
    int b;
    logic [63:0] exp;
    do_clear();
    do_insert(8'd10, b);
    do_insert(8'd20, b);
    do_insert(8'd30, b);
    @(negedge clk);
    en = 1'b1;
    X  = 8'd5;
    @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL midrst_data got %h want all ones", data); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL midrst_count got %0d want 0", count); end
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL midrst_rdy got %b want 1", rdy); end
    en = 1'b1;
    X  = 8'd70;
    @(posedge clk);
    #1 X = 8'd3;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (3) @(negedge clk);
    exp = {8'd70, 56'hFF_FFFF_FFFF_FFFF};
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL ignore_count got %0d want 1", count); end
    n_cmp++; if (data !== exp) begin n_bad++; $display("FAIL ignore_data got %h want %h", data, exp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_err();
    test_dup_and_clr();
    test_reset_mid_and_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
